// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
//
// Eight-requester round-robin arbiter for one shared datapath resource.
// A grant is held until the owner pulses done or drops its request. The
// optional hold-time limit can also force the release. Each release is
// followed by one dead GAP cycle, so two owners' selects never overlap.
//
// Configuration macro:
//   ARB_TIMEOUT_EN  defined    : hold counter active. A grant is force-released
//                                after HOLD_MAX cycles and timeout pulses once.
//                   undefined  : no counter logic is built and timeout is
//                                tied to 0.
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles (1..255), timeout build only
//   CW        hold counter width, HOLD_MAX < 2**CW
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req[7:0]   in   request levels, one per requester
//   done       in   single-cycle release pulse from the current owner
//   grant_vld  out  registered, a grant is active
//   grant_idx  out  registered index of the current owner
//   grant[7:0] out  one-hot decode of grant_idx, gated by grant_vld
//   timeout    out  registered single-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_vld,
    output logic [2:0] grant_idx,
    output logic [7:0] grant,
    output logic       timeout
);

    // Catch an illegal configuration at elaboration. Both builds check it.
    if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX >= (64'd1 << CW)) begin : g_bad_cfg
        $error("rr_arbiter8: HOLD_MAX must be 1..255 and below 2**CW");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       grant_vld_nxt;
    logic [2:0] grant_idx_nxt;
    logic [2:0] last, last_nxt;
    logic       timeout_nxt;

    // Rotating-priority search. Candidates are tried from last+1 upward,
    // modulo 8. The 3-bit sum wraps from 7 to 0 by itself. The last candidate
    // (k = 8) is "last" again, so a lone requester can be granted repeatedly.
    logic       found;
    logic [2:0] pick;
    logic [2:0] cand;

    // NOTE: every signal driven in an always_comb block gets a default value
    // first. Any path that leaves a signal unassigned would infer a latch.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = last;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] cnt, cnt_nxt;
    logic          hold_hit;

    // The counter reads 0 in the first GRANT cycle. A value of HOLD_MAX-1
    // therefore marks the last allowed cycle of the grant.
    assign hold_hit = (cnt == CW'(HOLD_MAX - 1));
`else
    logic          hold_hit;

    assign hold_hit = 1'b0;
`endif

    // The release is "timeout alone" only when the owner still wants the
    // resource and did not signal done in the same cycle.
    logic owner_req;
    logic release_now;
    logic forced;

    assign owner_req   = req[grant_idx];
    assign release_now = done | ~owner_req | hold_hit;
    assign forced      = hold_hit & ~done & owner_req;

    always_comb begin
        state_nxt     = state;
        grant_vld_nxt = grant_vld;
        grant_idx_nxt = grant_idx;
        last_nxt      = last;
        timeout_nxt   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_nxt       = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = GRANT;
                    grant_vld_nxt = 1'b1;
                    grant_idx_nxt = pick;
                    last_nxt      = pick;
`ifdef ARB_TIMEOUT_EN
                    cnt_nxt       = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (cnt != '1) cnt_nxt = cnt + 1'b1;
`endif
                if (release_now) begin
                    state_nxt     = GAP;
                    grant_vld_nxt = 1'b0;
                    timeout_nxt   = forced;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                grant_vld_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // All flops then sample the same pre-edge values, and no ordering race
    // can occur between processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_vld <= 1'b0;
            grant_idx <= 3'd0;
            last      <= 3'd7;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_vld <= grant_vld_nxt;
            grant_idx <= grant_idx_nxt;
            last      <= last_nxt;
            timeout   <= timeout_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;
    end
`endif

    // The select is decoded only from registered state. It therefore cannot
    // glitch when req changes.
    assign grant = grant_vld ? (8'b1 << grant_idx) : 8'h00;

endmodule

// File: tb/tb_rr_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter8
//
// Directed testbench for rr_arbiter8 with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [7:0] grant;
    logic       timeout;

    int tests_run = 0;
    int tests_failed = 0;

    rr_arbiter8 #(.HOLD_MAX(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all four outputs at once.
    task automatic check_out(input string tag, input logic vld, input logic [2:0] idx,
                             input logic [7:0] gnt, input logic to);
        check({tag, ".grant_vld"}, {7'd0, grant_vld}, {7'd0, vld});
        check({tag, ".grant_idx"}, {5'd0, grant_idx}, {5'd0, idx});
        check({tag, ".grant"}, grant, gnt);
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // No requests: the arbiter stays idle.
        for (int i = 0; i < 10; i++) begin
            step();
            check_out("idle", 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // All requests held, done pulsed: the grant rotates 0..7,0 and
        // every two grants are separated by two zero-grant cycles.
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            check_out("rotate", 1'b1, 3'(i % 8), 8'h01 << (i % 8), 1'b0);
            done = 1'b1;
            step();
            done = 1'b0;
            check("rotate.gap", grant, 8'h00);
            step();
            check("rotate.idle", grant, 8'h00);
        end
        req = 8'h00;
        step();
        check("rotate.stop", grant, 8'h00);

        // Serve requester 3, then req=24h. The expected order is 5, then 2.
        req = 8'h08;
        step();
        check_out("serve3", 1'b1, 3'd3, 8'h08, 1'b0);
        req = 8'h24;
        step();
        check_out("serve3.gap", 1'b0, 3'd3, 8'h00, 1'b0);
        step();
        check("serve3.idle", grant, 8'h00);
        step();
        check_out("pick5", 1'b1, 3'd5, 8'h20, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        check("pick5.gap", grant, 8'h00);
        step();
        check("pick5.idle", grant, 8'h00);
        step();
        check_out("pick2", 1'b1, 3'd2, 8'h04, 1'b0);
        req = 8'h00;
        step();
        check("pick2.gap", grant, 8'h00);
        step();

        // Owner 6 drops its request while requester 1 waits.
        req = 8'h40;
        step();
        check_out("own6", 1'b1, 3'd6, 8'h40, 1'b0);
        req = 8'h02;
        step();
        check_out("own6.drop", 1'b0, 3'd6, 8'h00, 1'b0);
        step();
        check("own6.idle", grant, 8'h00);
        step();
        check_out("own1", 1'b1, 3'd1, 8'h02, 1'b0);
        // Request changes from other requesters must not disturb the owner.
        req = 8'h83;
        step();
        check_out("own1.hold", 1'b1, 3'd1, 8'h02, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        check("own1.rel", grant, 8'h00);
        step();
        // done in IDLE is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        check_out("done_idle", 1'b0, 3'd1, 8'h00, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4: four grant cycles, then a timeout pulse during GAP.
        req = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("hold", 1'b1, 3'd0, 8'h01, 1'b0);
        end
        step();
        check_out("to.pulse", 1'b0, 3'd0, 8'h00, 1'b1);
        step();
        check_out("to.idle", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        check_out("to.regrant", 1'b1, 3'd0, 8'h01, 1'b0);
`else
        // Without the timeout feature, a held request keeps the grant.
        req = 8'h01;
        for (int i = 0; i < 20; i++) begin
            step();
            check_out("hold", 1'b1, 3'd0, 8'h01, 1'b0);
        end
`endif
        req = 8'h00;
        step();
        check("hold.rel", grant, 8'h00);
        step();

        // Asynchronous reset in the middle of a grant to requester 4.
        req = 8'h10;
        step();
        check_out("own4", 1'b1, 3'd4, 8'h10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
        req = 8'hFF;
        step();
        check_out("rst_hold", 1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("post_rst", 1'b1, 3'd0, 8'h01, 1'b0);
        req = 8'h00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
